// File: rtl/vel_dac_writer.sv
// vel_dac_writer: sends {CMD, CHAN, data} as a 24-bit SPI frame, MSB first, to the motor-current DAC.
// Build option VEL_DAC_MIDSCALE_EN: a falling edge on ctrl_enable queues one 8000h (zero-current) frame.
module vel_dac_writer #(
  parameter int         HALF = 2,
  parameter logic [3:0] CHAN = 4'h0,
  parameter logic [3:0] CMD  = 4'h3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_enable,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_data,
  output logic        dac_busy,
  output logic        dac_csn,
  output logic        dac_sclk,
  output logic        dac_mosi,
  output logic [15:0] last_word,
  output logic [15:0] frame_cnt
);

  localparam int            HW        = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] half_q, half_d;
  logic [4:0]    bit_q, bit_d;
  logic          phase_hi_q, phase_hi_d;
  logic [23:0]   shreg_q, shreg_d;
  logic          busy_q, busy_d;
  logic          csn_q, csn_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic [15:0]   last_word_q, last_word_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          pend_q;
  logic          take_mid_s;
  logic          half_end_s;
  logic [15:0]   start_word_s;

  assign half_end_s = (half_q == HALF_LAST);

`ifdef VEL_DAC_MIDSCALE_EN
  // en_sync_q[1:0] synchronise ctrl_enable; en_sync_q[2] is the previous synchronised level.
  logic [2:0] en_sync_q;
  logic       fall_s;
  logic       pend_d;

  assign fall_s = en_sync_q[2] & ~en_sync_q[1];

  always_comb begin
    pend_d = (pend_q & ~take_mid_s) | fall_s;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_sync_q <= 3'b000;
      pend_q    <= 1'b0;
    end else begin
      en_sync_q <= {en_sync_q[1:0], ctrl_enable};
      pend_q    <= pend_d;
    end
  end
`else
  logic unused_mid_s;
  assign pend_q       = 1'b0;
  assign unused_mid_s = ctrl_enable ^ take_mid_s;
`endif

  // State register plus frame datapath and registered pin drivers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      half_q      <= '0;
      bit_q       <= 5'd0;
      phase_hi_q  <= 1'b0;
      shreg_q     <= 24'h000000;
      busy_q      <= 1'b0;
      csn_q       <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      last_word_q <= 16'h8000;
      frame_cnt_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      bit_q       <= bit_d;
      phase_hi_q  <= phase_hi_d;
      shreg_q     <= shreg_d;
      busy_q      <= busy_d;
      csn_q       <= csn_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      last_word_q <= last_word_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    half_d       = half_q;
    bit_d        = bit_q;
    phase_hi_d   = phase_hi_q;
    shreg_d      = shreg_q;
    busy_d       = busy_q;
    last_word_d  = last_word_q;
    frame_cnt_d  = frame_cnt_q;
    take_mid_s   = 1'b0;
    start_word_s = cmd_data;
    case (state_q)
      ST_IDLE: begin
        // A queued midscale request wins over a fresh command.
        if (pend_q || cmd_valid) begin
          take_mid_s   = pend_q;
          start_word_s = pend_q ? 16'h8000 : cmd_data;
          shreg_d      = {CMD, CHAN, start_word_s};
          last_word_d  = start_word_s;
          busy_d       = 1'b1;
          half_d       = '0;
          state_d      = ST_LOAD;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (half_end_s) begin
          half_d     = '0;
          bit_d      = 5'd0;
          phase_hi_d = 1'b1;
          state_d    = ST_SHIFT;
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      ST_SHIFT: begin
        if (half_end_s) begin
          half_d = '0;
          if (phase_hi_q) begin
            phase_hi_d = 1'b0;
            shreg_d    = {shreg_q[22:0], 1'b0};
          end else if (bit_q == 5'd23) begin
            state_d = ST_HOLD;
          end else begin
            bit_d      = bit_q + 5'd1;
            phase_hi_d = 1'b1;
          end
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      ST_HOLD: begin
        if (half_end_s) begin
          half_d      = '0;
          busy_d      = 1'b0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_IDLE;
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pin levels decoded from the current state; registered, so the pins trail the state by one clk.
  always_comb begin
    csn_d  = 1'b1;
    sclk_d = 1'b0;
    mosi_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        csn_d = 1'b1;
      end
      ST_LOAD: begin
        csn_d  = 1'b0;
        mosi_d = shreg_q[23];
      end
      ST_SHIFT: begin
        csn_d  = 1'b0;
        sclk_d = phase_hi_q;
        mosi_d = shreg_q[23];
      end
      ST_HOLD: begin
        csn_d = 1'b1;
      end
      default: begin
        csn_d = 1'b1;
      end
    endcase
  end

  assign dac_busy  = busy_q;
  assign dac_csn   = csn_q;
  assign dac_sclk  = sclk_q;
  assign dac_mosi  = mosi_q;
  assign last_word = last_word_q;
  assign frame_cnt = frame_cnt_q;

endmodule
